// File: rtl/data_mem_ctrl_if.sv
// Load/store bus between the core, the data-memory controller and the data RAM.
// master = core plus RAM side, slave = controller.
interface data_mem_ctrl_if #(
    parameter int unsigned ADDR_W = 10
);
    logic              req_valid;
    logic              req_write;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              stall;
    logic [31:0]       rdata;
    logic              rdata_valid;
    logic              addr_err;
    logic              ram_en;
    logic [3:0]        ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_din;
    logic [31:0]       ram_dout;

    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, ram_dout,
        input  stall, rdata, rdata_valid, addr_err, ram_en, ram_we, ram_addr, ram_din
    );

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, ram_dout,
        output stall, rdata, rdata_valid, addr_err, ram_en, ram_we, ram_addr, ram_din
    );
endinterface

// File: rtl/data_mem_ctrl.sv
// Data-memory controller: byte/half/word stores with lane enables, aligned and
// extended loads, misalignment detection and a stall that covers RAM read latency.
module data_mem_ctrl #(
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned READ_LAT = 1
) (
    input  logic           clk,
    input  logic           rst,
    data_mem_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] WAIT_INIT = (READ_LAT >= 2) ? 2'(READ_LAT - 2) : 2'd0;

    if (READ_LAT < 1 || READ_LAT > 4) begin : g_bad_read_lat
        $error("data_mem_ctrl: READ_LAT must be in 1..4");
    end
    if (ADDR_W < 1 || ADDR_W > 29) begin : g_bad_addr_w
        $error("data_mem_ctrl: ADDR_W must be in 1..29");
    end

    state_t            state;
    logic [1:0]        cnt;
    logic [1:0]        lat_off;
    logic [1:0]        lat_size;
    logic              lat_signed;
    logic [ADDR_W-1:0] lat_addr;

    logic              misaligned_c;
    logic              load_start_c;
    logic [ADDR_W-1:0] req_word_c;
    logic [7:0]        ld_byte_c;
    logic [15:0]       ld_half_c;
    logic [31:0]       ld_data_c;

    // Bytes above the RAM window are dropped, so addresses wrap.
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.req_addr[31:ADDR_W+2];
    assign req_word_c     = bus.req_addr[ADDR_W+1:2];

    always_comb begin
        misaligned_c = 1'b1;
        case (bus.req_size)
            SIZE_BYTE: misaligned_c = 1'b0;
            SIZE_HALF: misaligned_c = bus.req_addr[0];
            SIZE_WORD: misaligned_c = |bus.req_addr[1:0];
            default:   misaligned_c = 1'b1;
        endcase
    end

    assign load_start_c = (state == IDLE) && bus.req_valid && !bus.req_write && !misaligned_c;

    // FSM and load-field latches; cnt counts the extra RAM wait cycles.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= 2'd0;
            lat_off    <= 2'd0;
            lat_size   <= 2'd0;
            lat_signed <= 1'b0;
            lat_addr   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_start_c) begin
                        lat_off    <= bus.req_addr[1:0];
                        lat_size   <= bus.req_size;
                        lat_signed <= bus.req_signed;
                        lat_addr   <= req_word_c;
                        if (READ_LAT == 1) begin
                            state <= DONE;
                        end else begin
                            state <= WAIT;
                            cnt   <= WAIT_INIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 2'd0) state <= DONE;
                    else             cnt   <= cnt - 2'd1;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Lane select and extension of the returned RAM word.
    always_comb begin
        ld_byte_c = bus.ram_dout[{lat_off, 3'b000} +: 8];
        ld_half_c = lat_off[1] ? bus.ram_dout[31:16] : bus.ram_dout[15:0];
        case (lat_size)
            SIZE_BYTE: ld_data_c = lat_signed ? {{24{ld_byte_c[7]}}, ld_byte_c} : {24'd0, ld_byte_c};
            SIZE_HALF: ld_data_c = lat_signed ? {{16{ld_half_c[15]}}, ld_half_c} : {16'd0, ld_half_c};
            default:   ld_data_c = bus.ram_dout;
        endcase
    end

    // Outputs; everything is held at zero while reset is asserted.
    always_comb begin
        bus.stall       = 1'b0;
        bus.rdata       = 32'd0;
        bus.rdata_valid = 1'b0;
        bus.addr_err    = 1'b0;
        bus.ram_en      = 1'b0;
        bus.ram_we      = 4'd0;
        bus.ram_addr    = '0;
        bus.ram_din     = 32'd0;
        if (rst) begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        if (misaligned_c) begin
                            bus.addr_err = 1'b1;
                        end else begin
                            bus.ram_en   = 1'b1;
                            bus.ram_addr = req_word_c;
                            if (bus.req_write) begin
                                case (bus.req_size)
                                    SIZE_BYTE: begin
                                        bus.ram_we  = 4'b0001 << bus.req_addr[1:0];
                                        bus.ram_din = {4{bus.req_wdata[7:0]}};
                                    end
                                    SIZE_HALF: begin
                                        bus.ram_we  = bus.req_addr[1] ? 4'b1100 : 4'b0011;
                                        bus.ram_din = {2{bus.req_wdata[15:0]}};
                                    end
                                    default: begin
                                        bus.ram_we  = 4'b1111;
                                        bus.ram_din = bus.req_wdata;
                                    end
                                endcase
                            end else begin
                                bus.stall = 1'b1;
                            end
                        end
                    end
                end
                WAIT: begin
                    bus.stall    = 1'b1;
                    bus.ram_en   = 1'b1;
                    bus.ram_addr = lat_addr;
                end
                DONE: begin
                    bus.rdata_valid = 1'b1;
                    bus.rdata       = ld_data_c;
                    bus.ram_addr    = lat_addr;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Parametrised data-memory controller between the `mips` core's load/store port and a synchronous-read `data_ram`. Supersedes the direct word-only hookup (`wea = {3'b0, memwrite}`, raw `douta`). Adds:
- byte/halfword/word stores with per-lane write enables;
- aligned, sign- or zero-extended loads;
- misalignment detection;
- a stall handshake that absorbs a configurable RAM read latency.

## Interface
- `ADDR_W`, default 10: RAM word-address width; RAM holds 2^ADDR_W 32-bit words.
- `READ_LAT`, default 1: RAM read latency in cycles, legal 1..4; other values are an elaboration error.

- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `req_valid`  in  1  core memory request present.
- `req_write`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- `req_signed`  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- `req_addr`  in  32  byte address (`alu_out`).
- `req_wdata`  in  32  store data, right-justified.
- `stall`  out  1  core must hold the request and freeze the PC.
- `rdata`  out  32  aligned, extended load result.
- `rdata_valid`  out  1  `rdata` valid this cycle.
- `addr_err`  out  1  misaligned or illegal-size request this cycle.
- `ram_en`  out  1  RAM enable.
- `ram_we`  out  4  RAM byte write enables; bit i = bits [8i+7:8i].
- `ram_addr`  out  ADDR_W  RAM word address.
- `ram_din`  out  32  RAM write data.
- `ram_dout`  in  32  RAM read data, valid `READ_LAT` cycles after address.

## Operation
- FSM states: `IDLE`, `WAIT`, `DONE`. A down-counter `cnt` (2 bits) is used in `WAIT`.
- Addressing:
  - `ram_addr = req_addr[ADDR_W+1:2]`.
  - Upper address bits are ignored, so addresses wrap modulo 2^(ADDR_W+2) bytes.
  - Byte order is little-endian.
- Alignment check, in `IDLE` with `req_valid = 1`:
  - Error cases: half with `addr[0] = 1`, word with `addr[1:0] != 0`, or `req_size = 11`.
  - Response: `addr_err = 1` in the same cycle, `ram_en = 0`, `ram_we = 0`, `stall = 0`; FSM stays in `IDLE`.
- Store, in `IDLE`, aligned:
  - Outputs: `ram_en = 1`, `stall = 0`; FSM stays in `IDLE`.
  - Byte: `ram_we = 1 << addr[1:0]`, `ram_din = {4{wdata[7:0]}}`.
  - Half: `ram_we = addr[1] ? 1100 : 0011`, `ram_din = {2{wdata[15:0]}}`.
  - Word: `ram_we = 1111`, `ram_din = wdata`.
- Load, in `IDLE`, aligned:
  - Outputs: `ram_en = 1`, `ram_we = 0`, `stall = 1`.
  - Latch `addr[1:0]`, `req_size`, `req_signed` and the word address.
  - Next state: `DONE` if `READ_LAT = 1`; otherwise `WAIT` with `cnt = READ_LAT - 2`.
- `WAIT`:
  - Outputs: `stall = 1`, `ram_en = 1`, `ram_addr` from the latched word address.
  - Transition: if `cnt = 0` go to `DONE`, else decrement `cnt`.
- `DONE`:
  - Outputs: `stall = 0`, `rdata_valid = 1`, `rdata` extracted combinationally from `ram_dout` using the latched fields.
  - Byte: lane `addr[1:0]`, extended per `req_signed`. Half: lane `addr[1]`, extended. Word: unchanged.
  - The request still present on the inputs is the load just served; it is not re-accepted.
  - Next state: `IDLE` unconditionally.
- `req_valid = 0` in `IDLE`: all RAM strobes 0, `stall = 0`.
- `rdata` = 0 whenever `rdata_valid = 0`.

## Timing
- While `rst = 0`, at and after the clock edge:
  - state = `IDLE`, `cnt` = 0, latched fields = 0.
  - All outputs forced to 0: `stall`, `rdata`, `rdata_valid`, `addr_err`, `ram_en`, `ram_we`, `ram_addr`, `ram_din`.
- Reset mid-load (`WAIT` or `DONE`):
  - The in-flight read is discarded and no `rdata_valid` is issued.
  - After `rst` returns high, the first request is sampled fresh.
- Store cost: 1 cycle, zero stall.
- Load accepted at cycle T:
  - `stall = 1` during cycles T .. T+READ_LAT-1.
  - `rdata_valid = 1` at cycle T+READ_LAT.
  - Next request is accepted at T+READ_LAT+1.
  - Total: READ_LAT+1 cycles per load.
- Error response: 1 cycle, zero stall; the core owns the exception.
- The core must keep all `req_*` inputs stable while `stall = 1` and through the `DONE` cycle.
- Back-to-back stores sustain 1 per cycle. A store directly after a load's `DONE` cycle is legal.
- Outputs are combinational from state plus request in `IDLE`, and from state plus latches in `WAIT`/`DONE`. No combinational path from `ram_dout` to `stall`.

## Test plan
- `READ_LAT = 1`: store word 0xDEADBEEF @0x10, then load word @0x10. Required: `ram_we = 1111`; `stall` high for 1 cycle; `rdata = 0xDEADBEEF` with `rdata_valid` in cycle 2.
- Byte stores 0x80 @0x21 and 0x7F @0x22:
  - Required `ram_we` values: 0010, then 0100.
  - Byte load @0x21 signed → 0xFFFFFF80; unsigned → 0x00000080.
  - Half load @0x22 signed → sign-extended upper halfword.
- Misalignment: half @0x13, word @0x12, `size = 11`. Required for each: `addr_err` 1 cycle, `ram_en = 0`, `stall = 0`, no RAM change.
- `READ_LAT = 3`: load accepted at T. Required: `stall` high for cycles T..T+2; `rdata_valid` only at T+3; next load accepted at T+4 with no duplicate read.
- Reset during `WAIT` (`READ_LAT = 4`), `rst` low for 1 cycle. Required: all outputs 0 next cycle; no `rdata_valid` ever for that load; the following store completes normally.
- Address @0x1000 with `ADDR_W = 10`. Required: `ram_addr = 0`, i.e. wrap-around.
